// File: rtl/ad7323_pkg.sv
// Shared constants, state encoding and word-building helpers for the AD7323 responder.
package ad7323_pkg;

    localparam int FRAME_BITS_DEF = 16;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;

    localparam int         WRITE_BIT   = 15;
    localparam int         REGSEL_MSB  = 14;
    localparam int         REGSEL_LSB  = 13;
    localparam logic [1:0] REGSEL_CTRL = 2'b00;
    localparam int         ADD_MSB     = 11;
    localparam int         ADD_LSB     = 10;
    localparam int         CODING_BIT  = 5;

    // Straight binary is two's complement with the sign bit flipped.
    function automatic logic [15:0] build_tx(input logic [1:0]  ch,
                                             input logic [12:0] data,
                                             input logic        straight);
        return {1'b0, ch, data[12] ^ straight, data[11:0]};
    endfunction

    function automatic logic is_ctrl_write(input logic [15:0] w);
        return w[WRITE_BIT] && (w[REGSEL_MSB:REGSEL_LSB] == REGSEL_CTRL);
    endfunction

endpackage

// File: rtl/ad7323_if.sv
// SPI pins between the ADC master and the AD7323 responder.
interface ad7323_if;
    logic CS;
    logic SCLK;
    logic DIN;
    logic DOUT;

    modport master (output CS, output SCLK, output DIN, input DOUT);
    modport slave  (input CS, input SCLK, input DIN, output DOUT);
endinterface

// File: rtl/ad7323_sync_edge.sv
// Multi-flop synchroniser with a registered copy for rise/fall detection.
module ad7323_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/ad7323_emulator.sv
// AD7323 SPI responder: decodes the control word of each frame and returns the selected channel.
module ad7323_emulator
    import ad7323_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = FRAME_BITS_DEF
) (
    input  logic               clk100MHz,
    input  logic               rst_n,
    ad7323_if.slave            spi,
    input  logic signed [12:0] ch0_in,
    input  logic signed [12:0] ch1_in,
    input  logic signed [12:0] ch2_in,
    input  logic signed [12:0] ch3_in,
    output logic [15:0]        ctrl_reg,
    output logic               frame_done,
    output logic               frame_err
);

    localparam int FLUSH_W = $clog2(SYNC_STAGES + 1) + 1;

    logic cs_sync, cs_rise, cs_fall;
    logic sclk_fall, sclk_sync_unused, sclk_rise_unused;
    logic [SYNC_STAGES-1:0] din_q;
    logic din_sync;

    ad7323_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(clk100MHz), .rst_n(rst_n), .async_i(spi.CS),
        .sync_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    ad7323_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
        .clk(clk100MHz), .rst_n(rst_n), .async_i(spi.SCLK),
        .sync_o(sclk_sync_unused), .rise_o(sclk_rise_unused), .fall_o(sclk_fall)
    );

    // DIN needs the same delay as SCLK so its value lines up with the detected fall.
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) din_q <= '0;
        else        din_q <= {din_q[SYNC_STAGES-2:0], spi.DIN};
    end
    assign din_sync = din_q[SYNC_STAGES-1];

    state_e         state_q, state_d;
    logic [4:0]     bitcnt_q, bitcnt_d;
    logic [15:0]    tx_q, tx_d;
    logic [15:0]    rx_q, rx_d;
    logic           dout_q, dout_d;
    logic           done_pend_q, done_pend_d;
    logic           err_pend_q, err_pend_d;
    logic [15:0]    ctrl_q;
    logic [1:0]     ch_ptr_q;
    logic           frame_done_q, frame_err_q;
    logic           armed_q;
    logic [FLUSH_W-1:0] flush_q;
    logic [12:0]    sample;

    always_comb begin
        sample = ch0_in;
        case (ch_ptr_q)
            2'd1:    sample = ch1_in;
            2'd2:    sample = ch2_in;
            2'd3:    sample = ch3_in;
            default: sample = ch0_in;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        dout_d      = dout_q;
        done_pend_d = 1'b0;
        err_pend_d  = 1'b0;
        case (state_q)
            IDLE: begin
                dout_d = 1'b0;
                if (cs_fall && armed_q) begin
                    tx_d     = build_tx(ch_ptr_q, sample, ctrl_q[CODING_BIT]);
                    rx_d     = '0;
                    dout_d   = tx_d[15];
                    bitcnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // A CS rise in the same cycle as an SCLK fall discards the fall.
                if (cs_rise) begin
                    err_pend_d = 1'b1;
                    dout_d     = 1'b0;
                    state_d    = IDLE;
                end else if (sclk_fall) begin
                    rx_d     = {rx_q[14:0], din_sync};
                    tx_d     = {tx_q[14:0], 1'b0};
                    dout_d   = tx_d[15];
                    bitcnt_d = bitcnt_q + 5'd1;
                    if (bitcnt_d == 5'(FRAME_BITS)) begin
                        dout_d  = 1'b0;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (cs_rise) begin
                    done_pend_d = 1'b1;
                    dout_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            dout_q      <= 1'b0;
            done_pend_q <= 1'b0;
            err_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            dout_q      <= dout_d;
            done_pend_q <= done_pend_d;
            err_pend_q  <= err_pend_d;
        end
    end

    // Commit one cycle after the rise is seen, alongside the pulse.
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q       <= '0;
            ch_ptr_q     <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            frame_done_q <= done_pend_q;
            frame_err_q  <= err_pend_q;
            if (done_pend_q && is_ctrl_write(rx_q)) begin
                ctrl_q   <= rx_q;
                ch_ptr_q <= rx_q[ADD_MSB:ADD_LSB];
            end
        end
    end

    // A CS already low at reset release must not start a frame until it has been seen high.
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            flush_q <= '0;
            armed_q <= 1'b0;
        end else begin
            if (flush_q != FLUSH_W'(SYNC_STAGES)) flush_q <= flush_q + FLUSH_W'(1);
            else if (cs_sync)                     armed_q <= 1'b1;
        end
    end

    assign spi.DOUT   = dout_q;
    assign ctrl_reg   = ctrl_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: doc/ad7323_emulator.md
# ad7323_emulator

Synthesizable responder for the AD7323 4-channel SPI ADC, driven by the existing ADC SPI master. It oversamples CS/SCLK/DIN on a fast system clock, decodes the control word written in each frame, and serialises a 16-bit result word on DOUT from four parallel sample inputs. It replaces the physical ADC for hardware-in-loop testing of the frequency-locking loop: voltage, phase_adj, current and power_adj on ch0..ch3.

## Interface
- SYNC_STAGES, 2, flip-flop depth of the CS/SCLK/DIN synchronisers.
- FRAME_BITS, 16, SCLK falling edges per valid frame.

- clk100MHz  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- CS  input  1  chip select from master, active low.
- SCLK  input  1  serial clock from master, idles high, ≤14.3 MHz, each phase ≥35 ns.
- DIN  input  1  control word from master, MSB first.
- DOUT  output  1  result word, MSB first; 0 while CS high.
- ch0_in..ch3_in  input  13 each  signed sample values, two's complement, −4096..4095.
- ctrl_reg  output  16  last committed control word.
- frame_done  output  1  one-cycle pulse: valid 16-bit frame committed.
- frame_err  output  1  one-cycle pulse: CS rose with fewer than FRAME_BITS falls.

## Operation
- CS, SCLK, DIN pass through SYNC_STAGES flops. Edges come from one extra registered copy. Sync flops reset to 1 (CS, SCLK) and 0 (DIN).
- States: IDLE, SHIFT, HOLD.
- IDLE: on CS fall:
  - latch sample of channel ch_ptr into tx word {1'b0, ch_ptr[1:0], data[12:0]};
  - if ctrl_reg[5]=1 (straight binary), data bit 12 is inverted;
  - DOUT ← tx bit 15; bitcnt ← 0; → SHIFT.
- SHIFT, on each SCLK fall:
  - rx ← {rx[14:0], DIN_sync};
  - tx shifts left; DOUT ← next bit;
  - bitcnt++.
  - When bitcnt reaches FRAME_BITS → HOLD, DOUT ← 0.
- HOLD: further SCLK edges are ignored.
- CS rise in HOLD → commit, then frame_done. Commit applies only if rx[15]=1 (WRITE) and rx[14:13]=00 (control register): ctrl_reg ← rx, ch_ptr ← rx[11:10]. Otherwise nothing is updated, but frame_done still pulses. → IDLE.
- CS rise in SHIFT → frame_err, no update → IDLE.
- Pipeline rule: the result in frame N is the channel selected by the write committed in frame N−1.
- CS fall while state ≠ IDLE cannot occur without an intervening CS rise. If CS is already low at reset release, wait for a rise then a fall.

## Timing
- Reset values: DOUT=0, ctrl_reg=16'h0000 (ch0, two's complement), ch_ptr=0, frame_done=0, frame_err=0, state IDLE, bitcnt=0.
- DOUT changes SYNC_STAGES+1 clk100MHz cycles (30 ns default) after the pin-level SCLK fall. The master therefore samples the previous bit on that same fall.
- Sample latch happens SYNC_STAGES+1 cycles after the CS fall. ch*_in must be stable from 40 ns before the CS fall.
- frame_done / frame_err assert SYNC_STAGES+2 cycles after the CS rise, for exactly one cycle. ctrl_reg updates in the same cycle as frame_done.
- CS rise and SCLK fall detected in the same cycle: CS rise wins, the SCLK edge is discarded.
- Asynchronous reset mid-frame clears everything immediately. The partial frame raises neither pulse.
- bitcnt is 5 bits and saturates at FRAME_BITS. There is no wrap.

## Structure
- Package ad7323_pkg holds:
  - FRAME_BITS default and state enum {IDLE, SHIFT, HOLD};
  - field constants WRITE_BIT=15, REGSEL_MSB/LSB=14/13, REGSEL_CTRL=2'b00, ADD_MSB/LSB=11/10, CODING_BIT=5.
- Sub-module ad7323_sync_edge: parameterised synchroniser plus rise/fall detector. Instanced for CS and SCLK; DIN uses its sync path only, so all three signals share the same delay.

## Test plan
- Reset, then frame writing 16'h8400 with ch0_in=13'h0123 → DOUT word 16'h0123, frame_done pulse, ctrl_reg=16'h8400.
- Next frame writes 16'h8400 with ch1_in=13'h1F00 → DOUT word 16'h3F00 (channel id 01 from the prior write).
- Write 16'h8420, then a frame with ch1_in=13'h1F00 → DOUT word 16'h2F00 (bit 12 inverted, straight binary).
- CS high after 10 SCLK falls while writing 16'h8C00 → frame_err pulse, no frame_done, ctrl_reg unchanged; next frame still returns ch_ptr's prior channel.
- Full frame writing 16'hA000 (range register) → frame_done pulses, ctrl_reg and ch_ptr unchanged.
- rst_n low after bit 7 of a frame → DOUT=0 immediately, ctrl_reg=0. After CS high then low, a full frame returns ch0 with channel id 00.
